regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port between two writeback requesters:
//   A (ALU/execute result) and M (load/memory result, multi-cycle).
//   Round-robin arbitration with valid/ready handshakes into a one-entry write stage.
//   The write stage drives the register file write port.
//   The stage contents are also exported as a forwarding source for operand reads.
// PARAMETERS
//   N     32  data width of a register / write data
//   XLEN  32  number of architectural registers; address width AW = log2(XLEN)
// PORTS
//   clk         in   1   clock, all state updates on rising edge
//   rst_n       in   1   asynchronous, active-low reset
//   a_valid     in   1   requester A holds a write
//   a_ready     out  1   A accepted this cycle (combinational)
//   a_addr      in   AW  A destination register
//   a_data      in   N   A write data
//   m_valid     in   1   requester M holds a write
//   m_ready     out  1   M accepted this cycle (combinational)
//   m_addr      in   AW  M destination register
//   m_data      in   N   M write data
//   rf_we       out  1   register file write enable
//   rf_addr     out  AW  register file write address
//   rf_data     out  N   register file write data
//   fwd_valid   out  1   write stage holds a pending write to a nonzero register
//   fwd_addr    out  AW  pending write address (equals rf_addr)
//   fwd_data    out  N   pending write data (equals rf_data)
// BEHAVIOUR
//   - Reset (rst_n=0, async): stage_valid=0, rf_we=0, rf_addr=0, rf_data=0, fwd_valid=0, prio=A.
//     Reset mid-operation discards any staged write; no write reaches the file.
//   - Grant (combinational, same cycle):
//     - Only A valid: grant A. Only M valid: grant M. Neither valid: no grant.
//     - Both valid: grant the side named by prio.
//     - a_ready = grant_A; m_ready = grant_M. At most one ready per cycle.
//   - Transfer: valid & ready on one side in the same cycle.
//     Requesters hold valid/addr/data stable until their ready is seen.
//   - prio updates on every transfer: grant A -> prio=M; grant M -> prio=A.
//     prio is unchanged when there is no transfer.
//     A continuously valid requester therefore waits at most 1 cycle.
//   - Write stage, updated on each rising edge:
//     - Transfer: stage_valid<=1; stage_addr/stage_data <= granted addr/data.
//     - No transfer: stage_valid<=0. Addr and data are held.
//   - Write port:
//     - rf_we = stage_valid && stage_addr!=0, so writes to x0 handshake but are dropped.
//     - rf_addr = stage_addr; rf_data = stage_data.
//     - Latency: handshake in cycle t -> rf_we high in cycle t+1 -> value readable from file in t+2.
//     - The stage drains unconditionally, so one write is accepted per cycle (full throughput).
//   - Forwarding:
//     - fwd_valid = rf_we; fwd_addr = rf_addr; fwd_data = rf_data.
//     - Readers compare their rs address with fwd_addr and prefer fwd_data on a match during t+1.
//   - Simultaneous same address from A and M: serialised by prio.
//     The later transfer writes last and its value persists.
// TESTING
//   1. Reset with rst_n low mid-stream (a_valid=1, addr 5) -> rf_we=0 immediately,
//      no write to x5 after release, prio=A.
//   2. a_valid only, addr 3, data 0xDEADBEEF -> a_ready=1 same cycle;
//      next cycle rf_we=1, rf_addr=3, rf_data=0xDEADBEEF, fwd_valid=1.
//   3. A and M both valid for 4 cycles (A: x1=0x11, M: x2=0x22) after reset
//      -> grants alternate A,M,A,M; rf_addr sequence 1,2,1,2.
//   4. Write to x0 (m_addr=0, data 0xFFFFFFFF) -> m_ready=1; next cycle rf_we=0, fwd_valid=0.
//   5. A and M both target x7 (A=0x1, M=0x2), prio=A -> x7 written 0x1 then 0x2;
//      final file value 0x2.
//   6. Back-to-back A writes x4=10, x5=20, x6=30 with M idle
//      -> three consecutive cycles with rf_we=1 and no bubble.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of two writeback requesters into a one-entry register-file write stage
`timescale 1ns/1ps
module regfile_wb_arbiter #(
  parameter int N    = 32,
  parameter int XLEN = 32,
  parameter int AW   = $clog2(XLEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [N-1:0]  a_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [AW-1:0] m_addr,
  input  logic [N-1:0]  m_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [N-1:0]  rf_data,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [N-1:0]  fwd_data
);
  // prio_q low favours A, high favours M
  logic          prio_q, prio_d;
  logic          stage_valid_q, stage_valid_d;
  logic [AW-1:0] stage_addr_q, stage_addr_d;
  logic [N-1:0]  stage_data_q, stage_data_d;
  always_comb begin
    a_ready       = a_valid && (!m_valid || !prio_q);
    m_ready       = m_valid && (!a_valid || prio_q);
    prio_d        = a_ready ? 1'b1 : m_ready ? 1'b0 : prio_q;
    stage_valid_d = a_ready || m_ready;
    stage_addr_d  = a_ready ? a_addr : m_ready ? m_addr : stage_addr_q;
    stage_data_d  = a_ready ? a_data : m_ready ? m_data : stage_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q        <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
    end else begin
      prio_q        <= prio_d;
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
    end
  end
  assign rf_we     = stage_valid_q && (stage_addr_q != '0);
  assign rf_addr   = stage_addr_q;
  assign rf_data   = stage_data_q;
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_addr;
  assign fwd_data  = rf_data;
endmodule
